// File: rtl/uart_fifo_bridge.sv
// Byte buffering between the CPU bus and the UART core: FWFT TX and RX FIFOs with level counts and sticky overflow flags.
// Optional macro UART_FIFO_IRQ_EN adds parameter RX_IRQ_LEVEL and a registered irq output.
module uart_fifo_bridge #(
    parameter int TX_DEPTH_LOG2 = 4,
    parameter int RX_DEPTH_LOG2 = 4
`ifdef UART_FIFO_IRQ_EN
    ,
    parameter int RX_IRQ_LEVEL = 1
`endif
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [7:0]               wr_data,
    input  logic                     wr_en,
    output logic                     tx_full,
    output logic [TX_DEPTH_LOG2:0]   tx_count,
    output logic                     tx_overflow,
    output logic [7:0]               rd_data,
    input  logic                     rd_en,
    output logic                     rx_empty,
    output logic [RX_DEPTH_LOG2:0]   rx_count,
    output logic                     rx_overflow,
    input  logic                     ovf_clear,
    output logic [7:0]               uart_data_in,
    output logic                     uart_transmit,
    input  logic                     uart_fetch,
    input  logic [7:0]               uart_data_out,
    input  logic                     uart_received
`ifdef UART_FIFO_IRQ_EN
    ,
    output logic                     irq
`endif
);

    localparam int TX_DEPTH = 1 << TX_DEPTH_LOG2;
    localparam int RX_DEPTH = 1 << RX_DEPTH_LOG2;
    localparam logic [TX_DEPTH_LOG2:0]   TX_FULL_C    = (TX_DEPTH_LOG2 + 1)'(TX_DEPTH);
    localparam logic [RX_DEPTH_LOG2:0]   RX_FULL_C    = (RX_DEPTH_LOG2 + 1)'(RX_DEPTH);
    localparam logic [TX_DEPTH_LOG2:0]   TX_CNT_ONE_C = {{TX_DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [RX_DEPTH_LOG2:0]   RX_CNT_ONE_C = {{RX_DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [TX_DEPTH_LOG2-1:0] TX_PTR_ONE_C = {{(TX_DEPTH_LOG2-1){1'b0}}, 1'b1};
    localparam logic [RX_DEPTH_LOG2-1:0] RX_PTR_ONE_C = {{(RX_DEPTH_LOG2-1){1'b0}}, 1'b1};

    logic [7:0]               tx_ram_r [0:TX_DEPTH-1];
    logic [7:0]               rx_ram_r [0:RX_DEPTH-1];
    logic [TX_DEPTH_LOG2-1:0] tx_wr_ptr_r, tx_rd_ptr_r;
    logic [RX_DEPTH_LOG2-1:0] rx_wr_ptr_r, rx_rd_ptr_r;
    logic [TX_DEPTH_LOG2:0]   tx_count_r, tx_count_s;
    logic [RX_DEPTH_LOG2:0]   rx_count_r, rx_count_s;
    logic                     tx_ovf_r, tx_ovf_s, rx_ovf_r, rx_ovf_s;
    logic                     tx_full_s, tx_empty_s, rx_full_s, rx_empty_s;
    logic                     tx_push_s, tx_pop_s, rx_push_s, rx_pop_s;

    // Flag decode, push/pop qualification and next count/overflow state.
    always_comb begin
        tx_full_s  = (tx_count_r == TX_FULL_C);
        tx_empty_s = (tx_count_r == {(TX_DEPTH_LOG2 + 1){1'b0}});
        rx_full_s  = (rx_count_r == RX_FULL_C);
        rx_empty_s = (rx_count_r == {(RX_DEPTH_LOG2 + 1){1'b0}});

        // A pop in the same cycle frees the slot, so a push at full still lands.
        tx_push_s = wr_en && (!tx_full_s || uart_fetch);
        tx_pop_s  = uart_fetch && !tx_empty_s;
        rx_push_s = uart_received && (!rx_full_s || rd_en);
        rx_pop_s  = rd_en && !rx_empty_s;

        tx_count_s = tx_count_r;
        case ({tx_push_s, tx_pop_s})
            2'b10:   tx_count_s = tx_count_r + TX_CNT_ONE_C;
            2'b01:   tx_count_s = tx_count_r - TX_CNT_ONE_C;
            default: tx_count_s = tx_count_r;
        endcase

        rx_count_s = rx_count_r;
        case ({rx_push_s, rx_pop_s})
            2'b10:   rx_count_s = rx_count_r + RX_CNT_ONE_C;
            2'b01:   rx_count_s = rx_count_r - RX_CNT_ONE_C;
            default: rx_count_s = rx_count_r;
        endcase

        // A set condition outranks a clear in the same cycle.
        tx_ovf_s = tx_ovf_r;
        if (wr_en && tx_full_s && !uart_fetch) begin
            tx_ovf_s = 1'b1;
        end else if (ovf_clear) begin
            tx_ovf_s = 1'b0;
        end else begin
            tx_ovf_s = tx_ovf_r;
        end

        rx_ovf_s = rx_ovf_r;
        if (uart_received && rx_full_s && !rd_en) begin
            rx_ovf_s = 1'b1;
        end else if (ovf_clear) begin
            rx_ovf_s = 1'b0;
        end else begin
            rx_ovf_s = rx_ovf_r;
        end
    end

    // Pointer, count and sticky flag registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            tx_wr_ptr_r <= {TX_DEPTH_LOG2{1'b0}};
            tx_rd_ptr_r <= {TX_DEPTH_LOG2{1'b0}};
            rx_wr_ptr_r <= {RX_DEPTH_LOG2{1'b0}};
            rx_rd_ptr_r <= {RX_DEPTH_LOG2{1'b0}};
            tx_count_r  <= {(TX_DEPTH_LOG2 + 1){1'b0}};
            rx_count_r  <= {(RX_DEPTH_LOG2 + 1){1'b0}};
            tx_ovf_r    <= 1'b0;
            rx_ovf_r    <= 1'b0;
        end else begin
            if (tx_push_s) tx_wr_ptr_r <= tx_wr_ptr_r + TX_PTR_ONE_C;
            if (tx_pop_s)  tx_rd_ptr_r <= tx_rd_ptr_r + TX_PTR_ONE_C;
            if (rx_push_s) rx_wr_ptr_r <= rx_wr_ptr_r + RX_PTR_ONE_C;
            if (rx_pop_s)  rx_rd_ptr_r <= rx_rd_ptr_r + RX_PTR_ONE_C;
            tx_count_r <= tx_count_s;
            rx_count_r <= rx_count_s;
            tx_ovf_r   <= tx_ovf_s;
            rx_ovf_r   <= rx_ovf_s;
        end
    end

    // Storage arrays; contents survive reset, only the pointers are cleared.
    always_ff @(posedge clk) begin
        if (reset && tx_push_s) tx_ram_r[tx_wr_ptr_r] <= wr_data;
        if (reset && rx_push_s) rx_ram_r[rx_wr_ptr_r] <= uart_data_out;
    end

    // First-word-fall-through head outputs and level reporting.
    always_comb begin
        uart_data_in  = tx_ram_r[tx_rd_ptr_r];
        uart_transmit = !tx_empty_s;
        tx_full       = tx_full_s;
        tx_count      = tx_count_r;
        tx_overflow   = tx_ovf_r;
        rx_empty      = rx_empty_s;
        rx_count      = rx_count_r;
        rx_overflow   = rx_ovf_r;
        if (rx_empty_s) begin
            rd_data = 8'h00;
        end else begin
            rd_data = rx_ram_r[rx_rd_ptr_r];
        end
    end

`ifdef UART_FIFO_IRQ_EN
    localparam logic [RX_DEPTH_LOG2:0] RX_IRQ_LEVEL_C = (RX_DEPTH_LOG2 + 1)'(RX_IRQ_LEVEL);
    logic irq_r;

    // Interrupt follows its causes with one cycle of latency.
    always_ff @(posedge clk) begin
        if (!reset) begin
            irq_r <= 1'b0;
        end else begin
            irq_r <= (rx_count_r >= RX_IRQ_LEVEL_C) || rx_ovf_r || tx_ovf_r;
        end
    end

    assign irq = irq_r;
`endif

endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Self-checking bench for uart_fifo_bridge: directed scenarios plus randomized traffic against a queue-based model.
module tb_uart_fifo_bridge;

    localparam int DEPTH = 16;
    localparam int IRQ_LEVEL = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] wr_data;
    logic       wr_en;
    logic       tx_full;
    logic [4:0] tx_count;
    logic       tx_overflow;
    logic [7:0] rd_data;
    logic       rd_en;
    logic       rx_empty;
    logic [4:0] rx_count;
    logic       rx_overflow;
    logic       ovf_clear;
    logic [7:0] uart_data_in;
    logic       uart_transmit;
    logic       uart_fetch;
    logic [7:0] uart_data_out;
    logic       uart_received;
`ifdef UART_FIFO_IRQ_EN
    logic       irq;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    logic       m_tx_ovf, m_rx_ovf, m_irq;

    always #5 clk = ~clk;

    uart_fifo_bridge #(
        .TX_DEPTH_LOG2(4),
        .RX_DEPTH_LOG2(4)
`ifdef UART_FIFO_IRQ_EN
        ,
        .RX_IRQ_LEVEL(IRQ_LEVEL)
`endif
    ) dut (
        .clk(clk),
        .reset(reset),
        .wr_data(wr_data),
        .wr_en(wr_en),
        .tx_full(tx_full),
        .tx_count(tx_count),
        .tx_overflow(tx_overflow),
        .rd_data(rd_data),
        .rd_en(rd_en),
        .rx_empty(rx_empty),
        .rx_count(rx_count),
        .rx_overflow(rx_overflow),
        .ovf_clear(ovf_clear),
        .uart_data_in(uart_data_in),
        .uart_transmit(uart_transmit),
        .uart_fetch(uart_fetch),
        .uart_data_out(uart_data_out),
        .uart_received(uart_received)
`ifdef UART_FIFO_IRQ_EN
        ,
        .irq(irq)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Apply current inputs for one clock edge, advance the model, then compare.
    task automatic tick();
        bit tx_pop, tx_push, tx_set, rx_pop, rx_push, rx_set, irq_next;
        @(posedge clk);
        if (!reset) begin
            tx_q.delete();
            rx_q.delete();
            m_tx_ovf = 1'b0;
            m_rx_ovf = 1'b0;
            m_irq    = 1'b0;
        end else begin
            irq_next = (rx_q.size() >= IRQ_LEVEL) || m_rx_ovf || m_tx_ovf;
            tx_pop  = uart_fetch && (tx_q.size() > 0);
            tx_push = wr_en && ((tx_q.size() < DEPTH) || uart_fetch);
            tx_set  = wr_en && (tx_q.size() == DEPTH) && !uart_fetch;
            rx_pop  = rd_en && (rx_q.size() > 0);
            rx_push = uart_received && ((rx_q.size() < DEPTH) || rd_en);
            rx_set  = uart_received && (rx_q.size() == DEPTH) && !rd_en;
            if (tx_pop)  void'(tx_q.pop_front());
            if (tx_push) tx_q.push_back(wr_data);
            if (rx_pop)  void'(rx_q.pop_front());
            if (rx_push) rx_q.push_back(uart_data_out);
            m_tx_ovf = tx_set ? 1'b1 : (ovf_clear ? 1'b0 : m_tx_ovf);
            m_rx_ovf = rx_set ? 1'b1 : (ovf_clear ? 1'b0 : m_rx_ovf);
            m_irq    = irq_next;
        end
        #1;
        check_eq("tx_count", tx_count, tx_q.size());
        check_eq("tx_full", tx_full, tx_q.size() == DEPTH);
        check_eq("uart_transmit", uart_transmit, tx_q.size() != 0);
        if (tx_q.size() != 0) check_eq("uart_data_in", uart_data_in, tx_q[0]);
        check_eq("rx_count", rx_count, rx_q.size());
        check_eq("rx_empty", rx_empty, rx_q.size() == 0);
        check_eq("rd_data", rd_data, (rx_q.size() == 0) ? 8'h00 : rx_q[0]);
        check_eq("tx_overflow", tx_overflow, m_tx_ovf);
        check_eq("rx_overflow", rx_overflow, m_rx_ovf);
`ifdef UART_FIFO_IRQ_EN
        check_eq("irq", irq, m_irq);
`endif
    endtask

    task automatic idle_inputs();
        reset = 1'b1; wr_en = 1'b0; wr_data = 8'h00; uart_fetch = 1'b0;
        uart_received = 1'b0; uart_data_out = 8'h00; rd_en = 1'b0; ovf_clear = 1'b0;
    endtask

    initial begin
        int p_wr, p_fetch, p_recv, p_rd, p_clr;
        idle_inputs();
        reset = 1'b0;
        tick(); tick();
        reset = 1'b1;
        tick(); tick();
        check_eq("reset_rd_data", rd_data, 32'h0);

        // Two bytes out through the transmitter handshake.
        wr_en = 1'b1; wr_data = 8'hA5; tick();
        wr_data = 8'h3C; tick();
        wr_en = 1'b0;
        check_eq("head_a5", uart_data_in, 32'hA5);
        uart_fetch = 1'b1; tick();
        check_eq("head_3c", uart_data_in, 32'h3C);
        tick();
        uart_fetch = 1'b0; tick();

        // Seventeen writes without fetch: last one overflows.
        wr_en = 1'b1;
        for (int i = 0; i < 17; i++) begin
            wr_data = 8'(8'h10 + i);
            tick();
        end
        wr_en = 1'b0;
        check_eq("tx_full_17", tx_full, 32'h1);
        check_eq("tx_ovf_17", tx_overflow, 32'h1);
        uart_fetch = 1'b1;
        for (int i = 0; i < 17; i++) tick();
        uart_fetch = 1'b0; ovf_clear = 1'b1; tick();
        ovf_clear = 1'b0;

        // Fill RX, then push+pop at full, then overflow against a clear.
        uart_received = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            uart_data_out = 8'(8'hC0 + i);
            tick();
        end
        uart_data_out = 8'h77; rd_en = 1'b1; tick();
        check_eq("rx_full_swap_count", rx_count, 32'd16);
        uart_data_out = 8'h88; rd_en = 1'b0; ovf_clear = 1'b1; tick();
        check_eq("rx_ovf_vs_clear", rx_overflow, 32'h1);
        uart_received = 1'b0; tick();
        check_eq("rx_ovf_cleared", rx_overflow, 32'h0);
        ovf_clear = 1'b0;
        rd_en = 1'b1;
        for (int i = 0; i < 17; i++) tick();
        rd_en = 1'b0; tick();

        // Randomized traffic in phases with different fill/drain bias.
        for (int ph = 0; ph < 6; ph++) begin
            case (ph % 3)
                0:       begin p_wr = 80; p_fetch = 20; p_recv = 80; p_rd = 20; end
                1:       begin p_wr = 20; p_fetch = 80; p_recv = 20; p_rd = 80; end
                default: begin p_wr = 50; p_fetch = 50; p_recv = 50; p_rd = 50; end
            endcase
            p_clr = 5;
            for (int c = 0; c < 600; c++) begin
                reset         = ($urandom_range(499) != 0);
                wr_en         = ($urandom_range(99) < p_wr);
                wr_data       = 8'($urandom);
                uart_fetch    = ($urandom_range(99) < p_fetch);
                uart_received = ($urandom_range(99) < p_recv);
                uart_data_out = 8'($urandom);
                rd_en         = ($urandom_range(99) < p_rd);
                ovf_clear     = ($urandom_range(99) < p_clr);
                tick();
            end
        end

        // Mid-traffic reset drops everything.
        idle_inputs();
        wr_en = 1'b1; uart_received = 1'b1; uart_data_out = 8'h5A; tick(); tick();
        idle_inputs(); reset = 1'b0; tick();
        reset = 1'b1; tick();
        check_eq("reset_drop_tx", tx_count, 32'd0);
        check_eq("reset_drop_rx", rx_empty, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
